// File: rtl/mac_serial_pkg.sv
// rtl/mac_serial_pkg.sv - shared state encoding and helpers for the serial MAC
package mac_serial_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      LOAD  = 2'd1,
      CALC  = 2'd2,
      SHIFT = 2'd3
   } state_t;

   // Smallest bit width able to hold values 0..value-1.
   function automatic int clog2(input int value);
      int r;
      r = 0;
      while ((1 << r) < value) r++;
      return r;
   endfunction

endpackage

// File: rtl/mac_serial_acc_if.sv
// rtl/mac_serial_acc_if.sv - serial operand/result bus of the serial MAC
interface mac_serial_acc_if;
   logic START;
   logic ACCUM;
   logic A;
   logic B;
   logic C;
   logic READY;
   logic O;
   logic O_VALID;
   logic END;
   logic OVF;

   modport master (
      output START, ACCUM, A, B, C,
      input  READY, O, O_VALID, END, OVF
   );

   modport slave (
      input  START, ACCUM, A, B, C,
      output READY, O, O_VALID, END, OVF
   );
endinterface

// File: rtl/mac_ser_shift.sv
// rtl/mac_ser_shift.sv - parallel-in serial-out register with a registered output bit
module mac_ser_shift #(
   parameter int N = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load,
   input  logic         shift,
   input  logic [N-1:0] par_data,
   output logic         ser_bit
);
   logic [N-1:0] data;

   // Load a word, then hand out one bit per shift, LSB first.
   always_ff @(posedge clk) begin
      if (rst) begin
         data    <= '0;
         ser_bit <= 1'b0;
      end else if (load) begin
         data    <= par_data;
         ser_bit <= 1'b0;
      end else if (shift) begin
         ser_bit <= data[0];
         data    <= {1'b0, data[N-1:1]};
      end
   end
endmodule

// File: rtl/mac_serial_acc.sv
// rtl/mac_serial_acc.sv - bit-serial multiply-accumulate with accumulate mode and overflow flag
module mac_serial_acc
   import mac_serial_pkg::*;
#(
   parameter int W      = 4,
   parameter int OW     = 2 * W,
   parameter int SIGNED = 0
) (
   input  logic            CLK,
   input  logic            RST,
   mac_serial_acc_if.slave bus
);
   localparam int CW = clog2(OW + 1);

   state_t          state;
   state_t          state_nxt;
   logic [CW-1:0]   cnt;
   logic [W-1:0]    a_q;
   logic [W-1:0]    b_q;
   logic [OW-1:0]   c_q;
   logic [OW-1:0]   acc_q;
   logic            accum_q;
   logic            ovf_q;
   logic            valid_q;
   logic            end_q;
   logic            load_sr;
   logic            shift_sr;
   logic            sout;
   logic [OW-1:0]   addend;
   logic [OW:0]     a_ext;
   logic [OW:0]     b_ext;
   logic [OW:0]     add_ext;
   logic [OW:0]     full;
   logic            ovf_calc;

   // State register.
   always_ff @(posedge CLK) begin
      if (RST) state <= IDLE;
      else     state <= state_nxt;
   end

   // Next state and serialiser control. SHIFT spends one extra cycle because
   // the output bit is registered inside the serialiser.
   always_comb begin
      state_nxt = state;
      load_sr   = 1'b0;
      shift_sr  = 1'b0;
      case (state)
         IDLE:  if (bus.START) state_nxt = LOAD;
         LOAD:  if (cnt == CW'(OW - 1)) state_nxt = CALC;
         CALC: begin
            load_sr   = 1'b1;
            state_nxt = SHIFT;
         end
         SHIFT: begin
            if (cnt == CW'(OW)) state_nxt = IDLE;
            else                shift_sr  = 1'b1;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Full-precision result in OW+1 bits; signed overflow means the top two bits disagree.
   always_comb begin
      addend   = accum_q ? acc_q : c_q;
      a_ext    = (SIGNED != 0) ? {{(OW + 1 - W){a_q[W-1]}}, a_q} : {{(OW + 1 - W){1'b0}}, a_q};
      b_ext    = (SIGNED != 0) ? {{(OW + 1 - W){b_q[W-1]}}, b_q} : {{(OW + 1 - W){1'b0}}, b_q};
      add_ext  = (SIGNED != 0) ? {addend[OW-1], addend} : {1'b0, addend};
      full     = a_ext * b_ext + add_ext;
      ovf_calc = (SIGNED != 0) ? (full[OW] != full[OW-1]) : full[OW];
   end

   // Operand capture (LSB first, shifted in from the top), bit counter, accumulator and flags.
   always_ff @(posedge CLK) begin
      if (RST) begin
         cnt     <= '0;
         a_q     <= '0;
         b_q     <= '0;
         c_q     <= '0;
         acc_q   <= '0;
         accum_q <= 1'b0;
         ovf_q   <= 1'b0;
         valid_q <= 1'b0;
         end_q   <= 1'b0;
      end else begin
         valid_q <= shift_sr;
         end_q   <= shift_sr && (cnt == CW'(OW - 1));
         case (state)
            IDLE: begin
               if (bus.START) begin
                  accum_q <= bus.ACCUM;
                  a_q     <= {bus.A, a_q[W-1:1]};
                  b_q     <= {bus.B, b_q[W-1:1]};
                  c_q     <= {bus.C, c_q[OW-1:1]};
                  cnt     <= CW'(1);
               end
            end
            LOAD: begin
               if (cnt < CW'(W)) begin
                  a_q <= {bus.A, a_q[W-1:1]};
                  b_q <= {bus.B, b_q[W-1:1]};
               end
               c_q <= {bus.C, c_q[OW-1:1]};
               cnt <= cnt + CW'(1);
            end
            CALC: begin
               acc_q <= full[OW-1:0];
               ovf_q <= ovf_calc;
               cnt   <= '0;
            end
            SHIFT: begin
               cnt <= (cnt == CW'(OW)) ? '0 : cnt + CW'(1);
            end
            default: cnt <= '0;
         endcase
      end
   end

   mac_ser_shift #(.N(OW)) u_shift (
      .clk      (CLK),
      .rst      (RST),
      .load     (load_sr),
      .shift    (shift_sr),
      .par_data (full[OW-1:0]),
      .ser_bit  (sout)
   );

   assign bus.READY   = (state == IDLE);
   assign bus.O       = sout & valid_q;
   assign bus.O_VALID = valid_q;
   assign bus.END     = end_q;
   assign bus.OVF     = ovf_q & valid_q;

endmodule

// File: tb/tb_mac_serial_acc.sv
// tb/tb_mac_serial_acc.sv - scoreboard bench for unsigned and signed serial MAC instances
module tb_mac_serial_acc;

   typedef struct packed {
      logic [7:0] r;
      logic       ovf;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic start_u = 1'b0;
   logic start_s = 1'b0;
   logic accum_in = 1'b0;
   logic a_in = 1'b0;
   logic b_in = 1'b0;
   logic c_in = 1'b0;

   logic [7:0] acc_u = 8'h00;
   logic [7:0] acc_s = 8'h00;
   exp_t       sb[$];
   int         checks = 0;
   int         errors = 0;

   mac_serial_acc_if bu();
   mac_serial_acc_if bs();

   assign bu.START = start_u;
   assign bu.ACCUM = accum_in;
   assign bu.A     = a_in;
   assign bu.B     = b_in;
   assign bu.C     = c_in;
   assign bs.START = start_s;
   assign bs.ACCUM = accum_in;
   assign bs.A     = a_in;
   assign bs.B     = b_in;
   assign bs.C     = c_in;

   mac_serial_acc #(.W(4), .OW(8), .SIGNED(0)) dut_u (.CLK(clk), .RST(rst), .bus(bu));
   mac_serial_acc #(.W(4), .OW(8), .SIGNED(1)) dut_s (.CLK(clk), .RST(rst), .bus(bs));

   always #5 clk = ~clk;

   function automatic exp_t model(input bit sgn, input bit accum, input logic [3:0] a,
                                  input logic [3:0] b, input logic [7:0] c, input logic [7:0] acc);
      exp_t       e;
      int         av, bv, dv, full;
      logic [7:0] add;
      add = accum ? acc : c;
      av  = int'(a);
      bv  = int'(b);
      dv  = int'(add);
      if (sgn) begin
         if (a[3])   av -= 16;
         if (b[3])   bv -= 16;
         if (add[7]) dv -= 256;
      end
      full  = av * bv + dv;
      e.r   = full[7:0];
      e.ovf = sgn ? (full < -128 || full > 127) : (full > 255);
      return e;
   endfunction

   task automatic drive_start(input bit sel, input bit val);
      if (sel) start_s = val;
      else     start_u = val;
   endtask

   // Drive one operation (START edge plus 7 LOAD edges) and push its expected result.
   task automatic op(input bit sel, input bit accum, input logic [3:0] a, input logic [3:0] b,
                     input logic [7:0] c, input int poke_k, output bit ready_at_poke);
      exp_t e;
      e = model(sel, accum, a, b, c, sel ? acc_s : acc_u);
      sb.push_back(e);
      if (sel) acc_s = e.r;
      else     acc_u = e.r;
      ready_at_poke = 1'b0;
      accum_in = accum;
      a_in = a[0];
      b_in = b[0];
      c_in = c[0];
      drive_start(sel, 1'b1);
      @(posedge clk);
      for (int k = 1; k < 8; k++) begin
         #1;
         drive_start(sel, k == poke_k);
         if (k == poke_k) ready_at_poke = sel ? bs.READY : bu.READY;
         accum_in = 1'($urandom_range(0, 1));
         a_in = (k < 4) ? a[k] : 1'($urandom_range(0, 1));
         b_in = (k < 4) ? b[k] : 1'($urandom_range(0, 1));
         c_in = c[k];
         @(posedge clk);
      end
      #1;
      drive_start(sel, 1'b0);
   endtask

   // Collect a serial result; negedge 1 is the one right after the last LOAD edge.
   task automatic capture(input bit sel, input int stop_after, input bit poke,
                          output logic [7:0] r, output int ovf_cnt, output int end_at,
                          output int first_n, output bit stray, output bit busy_ok,
                          output bit timeout);
      int idx;
      bit v, o, ov, e, poked;
      idx = 0; r = '0; ovf_cnt = 0; end_at = -1; first_n = -1;
      stray = 1'b0; busy_ok = 1'b1; timeout = 1'b1; poked = 1'b0;
      for (int n = 1; n <= 40; n++) begin
         @(negedge clk);
         if (poked) begin
            if ((sel ? bs.READY : bu.READY) !== 1'b0) busy_ok = 1'b0;
            drive_start(sel, 1'b0);
            poked = 1'b0;
         end
         v  = sel ? bs.O_VALID : bu.O_VALID;
         o  = sel ? bs.O       : bu.O;
         ov = sel ? bs.OVF     : bu.OVF;
         e  = sel ? bs.END     : bu.END;
         if (v) begin
            if (first_n < 0) first_n = n;
            if (idx < 8) r[idx[2:0]] = o;
            if (ov) ovf_cnt++;
            idx++;
            if (e) end_at = idx;
            if (poke && idx == 1) begin
               if ((sel ? bs.READY : bu.READY) !== 1'b0) busy_ok = 1'b0;
               drive_start(sel, 1'b1);
               poked = 1'b1;
            end
            if (e || idx == stop_after || idx > 8) begin
               timeout = !(e || idx == stop_after);
               break;
            end
         end else if (o || ov || e) begin
            stray = 1'b1;
         end
      end
      drive_start(sel, 1'b0);
   endtask

   task automatic test_reset();
      checks++; if (bu.READY !== 1'b1) begin errors++; $display("FAIL reset_ready_u: got %b want 1", bu.READY); end
      checks++; if (bs.READY !== 1'b1) begin errors++; $display("FAIL reset_ready_s: got %b want 1", bs.READY); end
      checks++; if ({bu.O, bu.O_VALID, bu.END, bu.OVF} !== 4'b0) begin errors++; $display("FAIL reset_outs_u: got %b want 0000", {bu.O, bu.O_VALID, bu.END, bu.OVF}); end
      checks++; if ({bs.O, bs.O_VALID, bs.END, bs.OVF} !== 4'b0) begin errors++; $display("FAIL reset_outs_s: got %b want 0000", {bs.O, bs.O_VALID, bs.END, bs.OVF}); end
   endtask

   task automatic test_basic();
      logic [7:0] r; int oc, ea, fn; bit st, bo, to, rdy; exp_t e;
      op(0, 0, 4'd5, 4'd10, 8'd3, 0, rdy);
      capture(0, 0, 0, r, oc, ea, fn, st, bo, to);
      e = sb.pop_front();
      checks++; if (to) begin errors++; $display("FAIL basic_timeout: no END seen"); end
      checks++; if (r !== e.r) begin errors++; $display("FAIL basic_r: got %h want %h", r, e.r); end
      checks++; if (r !== 8'h35) begin errors++; $display("FAIL basic_const: got %h want 35", r); end
      checks++; if (oc !== 0) begin errors++; $display("FAIL basic_ovf: got %0d want 0", oc); end
      checks++; if (ea !== 8) begin errors++; $display("FAIL basic_end: got %0d want 8", ea); end
      checks++; if (fn !== 3) begin errors++; $display("FAIL basic_latency: got %0d want 3", fn); end
      checks++; if (st) begin errors++; $display("FAIL basic_stray: got 1 want 0"); end
      @(posedge clk); #1;
      checks++; if (bu.READY !== 1'b1) begin errors++; $display("FAIL basic_ready_after: got %b want 1", bu.READY); end
   endtask

   task automatic test_overflow();
      logic [7:0] r; int oc, ea, fn; bit st, bo, to, rdy; exp_t e;
      op(0, 0, 4'd15, 4'd15, 8'd255, 0, rdy);
      capture(0, 0, 0, r, oc, ea, fn, st, bo, to);
      e = sb.pop_front();
      checks++; if (to) begin errors++; $display("FAIL ovf_timeout: no END seen"); end
      checks++; if (r !== e.r) begin errors++; $display("FAIL ovf_r: got %h want %h", r, e.r); end
      checks++; if (oc !== (e.ovf ? 8 : 0)) begin errors++; $display("FAIL ovf_flag: got %0d bits want %0d", oc, e.ovf ? 8 : 0); end
      @(posedge clk); #1;
   endtask

   task automatic test_accumulate();
      logic [7:0] r; int oc, ea, fn; bit st, bo, to, rdy; exp_t e;
      op(0, 0, 4'd5, 4'd10, 8'd3, 0, rdy);
      capture(0, 0, 0, r, oc, ea, fn, st, bo, to);
      e = sb.pop_front();
      checks++; if (r !== e.r) begin errors++; $display("FAIL acc_seed_r: got %h want %h", r, e.r); end
      @(posedge clk); #1;
      op(0, 1, 4'd2, 4'd3, 8'hFF, 0, rdy);
      capture(0, 0, 0, r, oc, ea, fn, st, bo, to);
      e = sb.pop_front();
      checks++; if (to) begin errors++; $display("FAIL acc_timeout: no END seen"); end
      checks++; if (r !== e.r) begin errors++; $display("FAIL acc_r: got %h want %h", r, e.r); end
      checks++; if (r !== 8'h3B) begin errors++; $display("FAIL acc_const: got %h want 3b", r); end
      @(posedge clk); #1;
   endtask

   task automatic test_back_to_back();
      logic [7:0] r; int oc, ea, fn; bit st, bo, to, rdy; exp_t e;
      op(0, 0, 4'd7, 4'd9, 8'h10, 3, rdy);
      checks++; if (rdy !== 1'b0) begin errors++; $display("FAIL busy_load_ready: got %b want 0", rdy); end
      capture(0, 0, 1, r, oc, ea, fn, st, bo, to);
      e = sb.pop_front();
      checks++; if (to) begin errors++; $display("FAIL busy_timeout: no END seen"); end
      checks++; if (bo !== 1'b1) begin errors++; $display("FAIL busy_shift_ready: got %b want 1", bo); end
      checks++; if (r !== e.r) begin errors++; $display("FAIL busy_r: got %h want %h", r, e.r); end
      checks++; if (ea !== 8) begin errors++; $display("FAIL busy_end: got %0d want 8", ea); end
      @(posedge clk); #1;
      checks++; if (bu.READY !== 1'b1) begin errors++; $display("FAIL b2b_ready: got %b want 1", bu.READY); end
      op(0, 0, 4'd1, 4'd1, 8'd1, 0, rdy);
      capture(0, 0, 0, r, oc, ea, fn, st, bo, to);
      e = sb.pop_front();
      checks++; if (r !== e.r) begin errors++; $display("FAIL b2b_r: got %h want %h", r, e.r); end
      checks++; if (fn !== 3) begin errors++; $display("FAIL b2b_latency: got %0d want 3", fn); end
      @(posedge clk); #1;
   endtask

   task automatic test_reset_mid_shift();
      logic [7:0] r; int oc, ea, fn; bit st, bo, to, rdy; exp_t e;
      op(0, 0, 4'd6, 4'd7, 8'h21, 0, rdy);
      capture(0, 3, 0, r, oc, ea, fn, st, bo, to);
      e = sb.pop_front();
      checks++; if (to) begin errors++; $display("FAIL rst_partial_timeout: 3 bits not seen"); end
      checks++; if (r[2:0] !== e.r[2:0]) begin errors++; $display("FAIL rst_partial_bits: got %b want %b", r[2:0], e.r[2:0]); end
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      acc_u = 8'h00;
      acc_s = 8'h00;
      checks++; if (bu.READY !== 1'b1) begin errors++; $display("FAIL rst_ready: got %b want 1", bu.READY); end
      checks++; if ({bu.O_VALID, bu.OVF} !== 2'b00) begin errors++; $display("FAIL rst_outs: got %b want 00", {bu.O_VALID, bu.OVF}); end
      op(0, 1, 4'd1, 4'd1, 8'hAA, 0, rdy);
      capture(0, 0, 0, r, oc, ea, fn, st, bo, to);
      e = sb.pop_front();
      checks++; if (r !== e.r) begin errors++; $display("FAIL rst_acc_r: got %h want %h", r, e.r); end
      checks++; if (r !== 8'h01) begin errors++; $display("FAIL rst_acc_const: got %h want 01", r); end
      @(posedge clk); #1;
   endtask

   task automatic test_signed();
      logic [7:0] r; int oc, ea, fn; bit st, bo, to, rdy; exp_t e;
      op(1, 0, 4'hD, 4'd5, 8'h00, 0, rdy);
      capture(1, 0, 0, r, oc, ea, fn, st, bo, to);
      e = sb.pop_front();
      checks++; if (to) begin errors++; $display("FAIL sgn_timeout: no END seen"); end
      checks++; if (r !== e.r) begin errors++; $display("FAIL sgn_r: got %h want %h", r, e.r); end
      checks++; if (r !== 8'hF1) begin errors++; $display("FAIL sgn_const: got %h want f1", r); end
      checks++; if (oc !== 0) begin errors++; $display("FAIL sgn_ovf: got %0d want 0", oc); end
      @(posedge clk); #1;
      op(1, 0, 4'h8, 4'h8, 8'd127, 0, rdy);
      capture(1, 0, 0, r, oc, ea, fn, st, bo, to);
      e = sb.pop_front();
      checks++; if (r !== e.r) begin errors++; $display("FAIL sgn_ovf_r: got %h want %h", r, e.r); end
      checks++; if (r !== 8'hBF) begin errors++; $display("FAIL sgn_ovf_const: got %h want bf", r); end
      checks++; if (oc !== (e.ovf ? 8 : 0)) begin errors++; $display("FAIL sgn_ovf_flag: got %0d bits want %0d", oc, e.ovf ? 8 : 0); end
      @(posedge clk); #1;
   endtask

   initial begin
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      test_reset();
      test_basic();
      test_overflow();
      test_accumulate();
      test_back_to_back();
      test_reset_mid_shift();
      test_signed();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/mac_serial_acc.md
Name: mac_serial_acc

Overview:
- Parametrised, bit-serial multiply-accumulate unit; next generation of the team's fixed-width serial MAC.
- Per operation: W-bit operands A and B and an OW-bit addend C arrive serially, LSB first; result R = A*B + addend goes out serially on O, LSB first.
- New over the previous generation: configurable operand/result width, signed mode, accumulate mode (addend = previous result instead of C), and an overflow flag.
- Sits between serial data sources and downstream serial consumers in the seminar datapath.

Parameters:
- W, 4, operand width of A and B, in bits (≥2).
- OW, 2*W, result/addend width in bits (≥2*W).
- SIGNED, 0, 0 = unsigned arithmetic; 1 = two's-complement operands, addend and result.

Ports:
- CLK  in  1  clock; all state updates on rising edge.
- RST  in  1  synchronous, active-high reset.
- START  in  1  operation request; accepted only when READY=1.
- ACCUM  in  1  sampled with START; 1 = addend is accumulator, 0 = addend is serial C.
- A  in  1  serial operand A, LSB first.
- B  in  1  serial operand B, LSB first.
- C  in  1  serial addend, LSB first.
- READY  out  1  high in IDLE only.
- O  out  1  serial result bit, LSB first.
- O_VALID  out  1  high while O carries a result bit.
- END  out  1  one-cycle pulse coincident with the last (MSB) result bit.
- OVF  out  1  held for the whole output burst; 1 if the true result does not fit in OW bits.

Behaviour:
- Reset (RST=1 at a rising edge), including mid-operation:
  - state → IDLE; accumulator, operand and output registers cleared.
  - READY=1; O, O_VALID, END, OVF = 0.
- States: IDLE → LOAD → CALC → SHIFT → IDLE.
- IDLE:
  - READY=1.
  - START=1 at edge t0 → LOAD; ACCUM latched; bit 0 of A, B and C sampled at that same edge.
- LOAD (bit counter k = 1..OW-1):
  - A[k] and B[k] sampled while k < W; A and B ignored for k ≥ W.
  - C[k] sampled for all k < OW.
  - START ignored throughout.
  - After the edge at t0+OW-1 → CALC.
- CALC (one cycle):
  - addend = latched ACCUM ? acc : C_reg.
  - Full result computed in OW+1 bits. Signed mode sign-extends A, B, product and addend; unsigned mode zero-extends.
  - Result truncated to OW bits → acc and the output shift register.
  - OVF: unsigned → bit OW of the full result set; signed → the truncated result ≠ the full result.
  - Next state → SHIFT.
- SHIFT (OW cycles):
  - O = shift-register LSB; O_VALID=1; register shifts right each cycle.
  - END=1 on the OW-th bit; then → IDLE and READY=1 in the next cycle.
- Latency: first result bit is valid in the cycle after edge t0+OW+1. Total occupancy is 2*OW+1 cycles from START to READY.
- START while busy: ignored; no queuing, and no effect on the operation in flight.
- START in the IDLE cycle immediately following END: accepted normally, giving back-to-back operations.
- Accumulator persists across operations; it is cleared only by RST.
- O and OVF are 0 whenever O_VALID=0.

Decomposition:
- Package mac_serial_pkg:
  - state enum {IDLE, LOAD, CALC, SHIFT}.
  - function clog2 for the bit-counter width.
- One sub-module: mac_ser_shift, a parametrised OW-bit PISO (parallel-in, serial-out) shift register with load and shift enables, used for the output serialiser.

Test Plan (W=4, OW=8 unless stated):
- Unsigned basic: ACCUM=0, A=5, B=10, C=3 → R=53=0x35; O bits 1,0,1,0,1,1,0,0; OVF=0; END on the 8th bit; first O_VALID at t0+10.
- Overflow: A=15, B=15, C=255 → full 480, O=0xE0; OVF=1 for all 8 bits.
- Accumulate: after the basic case, START with ACCUM=1, A=2, B=3, C=0xFF (ignored) → R=59=0x3B.
- Busy/back-to-back: START pulses during LOAD and SHIFT are ignored (READY stays 0). START in the first IDLE cycle after END is accepted with A=1, B=1, C=1 → R=2.
- Reset mid-SHIFT: RST=1 after 3 output bits → next cycle READY=1, O_VALID=0, OVF=0. A following ACCUM=1 op with A=1, B=1 → R=1 (accumulator was cleared).
- Signed (SIGNED=1): A=-3 (1101), B=5, C=0 → R=-15=0xF1, OVF=0. Also A=-8, B=-8, C=127 (OW=8) → full 191 → OVF=1, O=0xBF.
